// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding and counter sizing for the reset sequencer.
package rst_seq_pkg;
  typedef enum logic [1:0] {HOLD, STEP, RUN, SOFT} rst_seq_state_t;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/rst_deassert_sync.sv
// rst_deassert_sync: 2-flop reset synchronizer, asserts asynchronously, deasserts on clk.
module rst_deassert_sync (
  input  logic clk,
  input  logic rst,
  output logic rst_sync
);
  logic [1:0] q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 2'b11;
    else q <= {q[0], 1'b0};
  assign rst_sync = q[1];
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staggered per-domain reset release with soft-reset re-sequencing.
// Define RST_SEQ_WDT_EN to add the RUN-state watchdog (wdt_kick/wdt_fired).
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int N_DOM    = 3,
  parameter int HOLD_CYC = 16,
  parameter int STEP_CYC = 4,
  parameter int SOFT_MIN = 8,
  parameter int WDT_CYC  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_req,
  output logic             soft_ack,
  output logic [N_DOM-1:0] dom_rst_n,
  output logic             all_ready
`ifdef RST_SEQ_WDT_EN
  ,
  input  logic             wdt_kick,
  output logic             wdt_fired
`endif
);
  localparam int CW = cnt_w(HOLD_CYC, STEP_CYC, SOFT_MIN);
  localparam int IW = $clog2(N_DOM) + 1;
  logic rst_i;
  rst_seq_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [N_DOM-1:0] dom_nx;
  logic ack_nx, rdy_nx, wdt_hit;
  rst_deassert_sync u_sync (
    .clk(clk),
    .rst(rst),
    .rst_sync(rst_i)
  );
`ifdef RST_SEQ_WDT_EN
  localparam int WW = $clog2(WDT_CYC + 1);
  logic [WW-1:0] wcnt;
  assign wdt_hit = state == RUN && !wdt_kick && wcnt == WW'(WDT_CYC - 1);
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      wcnt <= '0;
      wdt_fired <= 1'b0;
    end else begin
      wcnt <= (state != RUN || wdt_kick || wdt_hit) ? '0 : wcnt + 1'b1;
      wdt_fired <= wdt_fired | wdt_hit;
    end
`else
  assign wdt_hit = WDT_CYC < 0;
`endif
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      state <= HOLD;
      cnt <= '0;
      idx <= '0;
      dom_rst_n <= '0;
      soft_ack <= 1'b0;
      all_ready <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      idx <= idx_nx;
      dom_rst_n <= dom_nx;
      soft_ack <= ack_nx;
      all_ready <= rdy_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    idx_nx = idx;
    dom_nx = dom_rst_n;
    ack_nx = 1'b0;
    rdy_nx = all_ready;
    unique case (state)
      HOLD:
        if (cnt == CW'(HOLD_CYC - 1)) begin
          dom_nx = dom_rst_n | N_DOM'(1);
          idx_nx = IW'(1);
          cnt_nx = '0;
          state_nx = (N_DOM == 1) ? RUN : STEP;
          rdy_nx = (N_DOM == 1);
        end else cnt_nx = cnt + 1'b1;
      STEP:
        if (cnt == CW'(STEP_CYC - 1)) begin
          dom_nx = dom_rst_n | (N_DOM'(1) << idx);
          cnt_nx = '0;
          state_nx = (idx == IW'(N_DOM - 1)) ? RUN : STEP;
          rdy_nx = (idx == IW'(N_DOM - 1));
          idx_nx = (idx == IW'(N_DOM - 1)) ? idx : idx + 1'b1;
        end else cnt_nx = cnt + 1'b1;
      RUN:
        if (soft_req || wdt_hit) begin
          ack_nx = 1'b1;
          dom_nx = '0;
          rdy_nx = 1'b0;
          cnt_nx = '0;
          state_nx = SOFT;
        end
      SOFT:
        // saturate, then leave only once the request has dropped
        if (cnt != CW'(SOFT_MIN - 1)) cnt_nx = cnt + 1'b1;
        else if (!soft_req) begin
          cnt_nx = '0;
          state_nx = HOLD;
        end
      default: state_nx = HOLD;
    endcase
  end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: randomized scoreboard bench for rst_seq_ctrl (RST_SEQ_WDT_EN aware).
module tb_rst_seq_ctrl;
  localparam int N = 3, H = 16, S = 4, M = 8, W = 64;
`ifdef RST_SEQ_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif
  localparam int M_RST = 0, M_SEQ = 1, M_RUN = 2, M_SOFT = 3;
  typedef struct {
    int cyc;
    logic [N-1:0] dom;
    logic rdy;
    logic ack;
    logic fired;
  } ev_t;
  logic clk = 1'b0, rst = 1'b0, soft_req = 1'b0, wdt_kick = 1'b0;
  logic soft_ack, all_ready, wdt_fired;
  logic [N-1:0] dom_rst_n;
  int cyc = 0, checks = 0, errors = 0;
  ev_t q[$];
  int m_mode = M_RST, t0 = 0, te = 0, wref = 0;
  logic req_p = 1'b0, kick_p = 1'b0;
  logic [N-1:0] x_dom = '0;
  logic x_rdy = 1'b0, x_ack = 1'b0, x_fired = 1'b0;
  ev_t last = '{0, '0, 1'b0, 1'b0, 1'b0};

  rst_seq_ctrl #(
    .N_DOM(N), .HOLD_CYC(H), .STEP_CYC(S), .SOFT_MIN(M), .WDT_CYC(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .soft_req(soft_req),
    .soft_ack(soft_ack),
    .dom_rst_n(dom_rst_n),
    .all_ready(all_ready)
`ifdef RST_SEQ_WDT_EN
    ,
    .wdt_kick(wdt_kick),
    .wdt_fired(wdt_fired)
`endif
  );
`ifndef RST_SEQ_WDT_EN
  assign wdt_fired = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: outputs after edge cyc, from elapsed time since the sequence origin
  always @(negedge clk) begin
    int rel;
    logic fire;
    ev_t e;
    x_ack = 1'b0;
    if (rst) begin
      m_mode = M_RST;
      x_dom = '0;
      x_rdy = 1'b0;
      x_fired = 1'b0;
    end else if (m_mode == M_RST) begin
      m_mode = M_SEQ;
      t0 = cyc + 2;
    end else if (m_mode == M_SEQ) begin
      rel = (cyc >= t0 + H) ? (cyc - t0 - H) / S + 1 : 0;
      if (rel > N) rel = N;
      x_dom = N'((1 << rel) - 1);
      x_rdy = (rel == N);
      if (x_rdy) begin
        m_mode = M_RUN;
        wref = cyc;
      end
    end else if (m_mode == M_RUN) begin
      if (kick_p) wref = cyc;
      fire = WDT && !kick_p && (cyc - wref == W);
      if (req_p || fire) begin
        x_ack = 1'b1;
        x_dom = '0;
        x_rdy = 1'b0;
        x_fired = x_fired | fire;
        m_mode = M_SOFT;
        te = cyc;
      end
    end else if (cyc - te >= M && !req_p) begin
      m_mode = M_SEQ;
      t0 = cyc;
    end
    req_p = soft_req;
    kick_p = wdt_kick;
    if (x_dom != last.dom || x_rdy != last.rdy || x_ack != last.ack || x_fired != last.fired) begin
      e = '{cyc, x_dom, x_rdy, x_ack, x_fired};
      q.push_back(e);
      last = e;
    end
  end

  initial begin
    logic [N-1:0] pd;
    logic pr, pa, pf;
    ev_t e;
    pd = '0;
    pr = 1'b0;
    pa = 1'b0;
    pf = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        checks++;
        if (dom_rst_n !== '0 || all_ready !== 1'b0 || soft_ack !== 1'b0 || wdt_fired !== 1'b0) begin
          errors++;
          $display("FAIL reset_state cyc=%0d got dom=%b rdy=%b ack=%b fired=%b need all zero",
                   cyc, dom_rst_n, all_ready, soft_ack, wdt_fired);
        end
      end
      if (dom_rst_n !== pd || all_ready !== pr || soft_ack !== pa || wdt_fired !== pf) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got dom=%b rdy=%b ack=%b fired=%b need no change",
                   cyc, dom_rst_n, all_ready, soft_ack, wdt_fired);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.dom !== dom_rst_n || e.rdy !== all_ready || e.ack !== soft_ack ||
              e.fired !== wdt_fired) begin
            errors++;
            $display("FAIL output_event got cyc=%0d dom=%b rdy=%b ack=%b fired=%b need cyc=%0d dom=%b rdy=%b ack=%b fired=%b",
                     cyc, dom_rst_n, all_ready, soft_ack, wdt_fired, e.cyc, e.dom, e.rdy, e.ack, e.fired);
          end
        end
        pd = dom_rst_n;
        pr = all_ready;
        pa = soft_ack;
        pf = wdt_fired;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run;
    int n = 0;
    do begin
      tick();
      n++;
    end while (m_mode != M_RUN && n < 400);
    if (m_mode != M_RUN) begin
      errors++;
      $display("FAIL wait_run got mode=%0d need RUN within 400 cycles", m_mode);
    end
  endtask

  task automatic pulse_req(input int len);
    soft_req = 1'b1;
    repeat (len) tick();
    soft_req = 1'b0;
  endtask

  initial begin
    int kind;
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    wait_run();
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 5)) tick();
      kind = (i < 4) ? i : int'($urandom_range(0, 3));
      case (kind)
        0: pulse_req($urandom_range(1, 3));
        1: pulse_req($urandom_range(9, 40));
        2: begin
          pulse_req(1);
          repeat ($urandom_range(0, 30)) tick();
          pulse_req($urandom_range(1, 30));
        end
        default: begin
          pulse_req(1);
          repeat ($urandom_range(0, 35)) tick();
          rst = 1'b1;
          repeat ($urandom_range(1, 3)) tick();
          rst = 1'b0;
        end
      endcase
      wait_run();
    end
`ifdef RST_SEQ_WDT_EN
    repeat (5) begin
      wdt_kick = 1'b1;
      tick();
      wdt_kick = 1'b0;
      repeat (31) tick();
    end
    for (int n = 0; n < 100 && m_mode == M_RUN; n++) tick();
    wait_run();
`endif
    repeat (10) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d outstanding need 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
